// File: rtl/result_display.sv
// Result display: captures the ALU result on a show opcode, converts it to BCD
// with a sequential double-dabble and scans it onto a 3-digit seven-segment display.
module result_display #(
    parameter int unsigned SCAN_DIV = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] Result,
    input  logic [2:0] Sel,
    output logic [6:0] Seg,
    output logic [2:0] An,
    output logic       Busy
);
    localparam int unsigned RES_W  = 8;
    localparam int unsigned DIG_W  = 4;
    localparam int unsigned BCD_W  = 3 * DIG_W;
    localparam int unsigned ITER_W = 3;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned AN_W   = 3;
    localparam int unsigned SEL_W  = 3;

    localparam logic [SEL_W-1:0]  SEL_SHOW     = 3'b011;
    localparam logic [SEL_W-1:0]  SEL_CLEAR    = 3'b100;
    localparam logic [ITER_W-1:0] ITER_LAST    = ITER_W'(RES_W - 1);
    localparam logic [CNT_W-1:0]  SCAN_LAST    = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_UNITS    = 2'd0;
    localparam logic [IDX_W-1:0]  IDX_TENS     = 2'd1;
    localparam logic [IDX_W-1:0]  IDX_HUNDREDS = 2'd2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic                show_q, show_d;
    logic [RES_W-1:0]    sh_q, sh_d;
    logic [BCD_W-1:0]    acc_q, acc_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic                busy_q, busy_d;
    logic [BCD_W-1:0]    dig_q, dig_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [SEG_W-1:0]    seg_q, seg_d;
    logic [AN_W-1:0]     an_q, an_d;

    logic                show_c;
    logic                clear_c;
    logic                start_c;
    logic [BCD_W-1:0]    adj_c;
    logic [BCD_W-1:0]    acc_step_c;
    logic [RES_W-1:0]    sh_step_c;
    logic [DIG_W-1:0]    digit_c;
    logic                blank_c;

    function automatic logic [DIG_W-1:0] add3(input logic [DIG_W-1:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [SEG_W-1:0] seg_decode(input logic [DIG_W-1:0] d);
        logic [SEG_W-1:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Opcode decode; a show only starts on the first cycle the opcode appears.
    always_comb begin
        show_c  = (Sel == SEL_SHOW);
        clear_c = (Sel == SEL_CLEAR);
        start_c = show_c & ~show_q;
        show_d  = show_c;
    end

    // One double-dabble step: add-3 on nibbles >= 5, then shift left by one.
    always_comb begin
        adj_c      = {add3(acc_q[11:8]), add3(acc_q[7:4]), add3(acc_q[3:0])};
        acc_step_c = {adj_c[BCD_W-2:0], sh_q[RES_W-1]};
        sh_step_c  = {sh_q[RES_W-2:0], 1'b0};
    end

    // Conversion FSM next state; clear overrides everything.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        iter_d  = iter_q;
        busy_d  = busy_q;
        dig_d   = dig_q;

        if (clear_c) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            dig_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_c) begin
                        sh_d    = Result;
                        acc_d   = '0;
                        iter_d  = '0;
                        busy_d  = 1'b1;
                        state_d = ST_CONV;
                    end
                end
                ST_CONV: begin
                    sh_d   = sh_step_c;
                    acc_d  = acc_step_c;
                    iter_d = iter_q + ITER_W'(1);
                    if (iter_q == ITER_LAST) begin
                        dig_d   = acc_step_c;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            show_q  <= 1'b0;
            sh_q    <= '0;
            acc_q   <= '0;
            iter_q  <= '0;
            busy_q  <= 1'b0;
            dig_q   <= '0;
        end else begin
            state_q <= state_d;
            show_q  <= show_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            iter_q  <= iter_d;
            busy_q  <= busy_d;
            dig_q   <= dig_d;
        end
    end

    // Scan timing: dwell SCAN_DIV cycles per digit, units -> tens -> hundreds.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == SCAN_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_HUNDREDS) ? IDX_UNITS : idx_q + IDX_W'(1);
        end
    end

    // Segment/anode drive from the current index, with leading-zero blanking.
    always_comb begin
        case (idx_q)
            IDX_UNITS: begin
                digit_c = dig_q[3:0];
                blank_c = 1'b0;
                an_d    = 3'b001;
            end
            IDX_TENS: begin
                digit_c = dig_q[7:4];
                blank_c = (dig_q[11:8] == 4'd0) && (dig_q[7:4] == 4'd0);
                an_d    = 3'b010;
            end
            default: begin
                digit_c = dig_q[11:8];
                blank_c = (dig_q[11:8] == 4'd0);
                an_d    = 3'b100;
            end
        endcase
        seg_d = blank_c ? '0 : seg_decode(digit_c);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            idx_q <= IDX_UNITS;
            seg_q <= '0;
            an_q  <= 3'b001;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign Seg  = seg_q;
    assign An   = an_q;
    assign Busy = busy_q;

endmodule

// File: tb/tb_result_display.sv
// Self-checking bench for result_display: scenario tasks compare the DUT against
// digit/blanking/scan expectations derived arithmetically from the shown value.
module tb_result_display;
    localparam int unsigned SCAN_DIV  = 4;
    localparam int unsigned CAP_LIMIT = 3 * SCAN_DIV + 3;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] Result;
    logic [2:0] Sel;
    logic [6:0] Seg;
    logic [2:0] An;
    logic       Busy;

    int checks   = 0;
    int failures = 0;
    int shown    = 0;

    result_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .Result (Result),
        .Sel    (Sel),
        .Seg    (Seg),
        .An     (An),
        .Busy   (Busy)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] seg_pat(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    // Expected segment pattern of position pos (0=units,1=tens,2=hundreds) for value v.
    function automatic logic [6:0] exp_seg(input int v, input int pos);
        int h;
        int t;
        int u;
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        if (pos == 2) return (h == 0) ? 7'b0 : seg_pat(h);
        if (pos == 1) return (h == 0 && t == 0) ? 7'b0 : seg_pat(t);
        return seg_pat(u);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_show(input int v, output int busy_cycles);
        Result = 8'(v);
        Sel    = 3'b011;
        tick();
        Sel    = 3'b000;
        Result = 8'($urandom_range(0, 255));
        busy_cycles = 0;
        for (int g = 0; g < 20 && Busy === 1'b1; g++) begin
            busy_cycles++;
            tick();
        end
    endtask

    task automatic capture(output logic [20:0] cap, output bit ok);
        logic [2:0] seen;
        seen = 3'b000;
        cap  = '0;
        tick();
        for (int i = 0; i < CAP_LIMIT; i++) begin
            for (int k = 0; k < 3; k++) begin
                if (An === 3'(1 << k)) begin
                    cap[k*7 +: 7] = Seg;
                    seen[k]       = 1'b1;
                end
            end
            tick();
        end
        ok = &seen;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        Sel     = 3'b000;
        Result  = 8'd0;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (Seg !== 7'b0) begin failures++; $display("FAIL reset_seg got=%b exp=%b", Seg, 7'b0); end
        checks++; if (An !== 3'b001) begin failures++; $display("FAIL reset_an got=%b exp=%b", An, 3'b001); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", Busy); end
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        checks++; if (Seg !== 7'b0 || An !== 3'b001) begin
            failures++; $display("FAIL release_state seg=%b an=%b exp seg=0 an=001", Seg, An);
        end
    endtask

    // Scan sequence from reset with all digits zero: only units lit.
    task automatic test_scan();
        int idx;
        logic [2:0] ean;
        logic [6:0] eseg;
        for (int n = 1; n <= 30; n++) begin
            tick();
            idx  = ((n - 1) / SCAN_DIV) % 3;
            ean  = 3'(1 << idx);
            eseg = (idx == 0) ? 7'b0111111 : 7'b0;
            checks++; if (An !== ean) begin failures++; $display("FAIL scan_an n=%0d got=%b exp=%b", n, An, ean); end
            checks++; if (Seg !== eseg) begin failures++; $display("FAIL scan_seg n=%0d got=%b exp=%b", n, Seg, eseg); end
            checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL scan_busy n=%0d got=%b exp=0", n, Busy); end
        end
    endtask

    task automatic test_show_237();
        int bc;
        int k;
        logic [20:0] cap;
        bit ok;
        run_show(237, bc);
        checks++; if (bc != 8) begin failures++; $display("FAIL show237_busy got=%0d exp=8", bc); end
        capture(cap, ok);
        checks++; if (!ok) begin failures++; $display("FAIL show237_scan got=missing_digit exp=all_three"); end
        for (int p = 0; p < 3; p++) begin
            checks++;
            if (cap[p*7 +: 7] !== exp_seg(237, p)) begin
                failures++; $display("FAIL show237_digit%0d got=%b exp=%b", p, cap[p*7 +: 7], exp_seg(237, p));
            end
        end
        // An and Seg must stay paired on every cycle of the scan.
        for (int i = 0; i < 12; i++) begin
            k = (An === 3'b001) ? 0 : (An === 3'b010) ? 1 : (An === 3'b100) ? 2 : -1;
            checks++;
            if (k < 0) begin
                failures++; $display("FAIL show237_onehot got=%b exp=one_hot", An);
            end else if (Seg !== exp_seg(237, k)) begin
                failures++; $display("FAIL show237_pair an=%b got=%b exp=%b", An, Seg, exp_seg(237, k));
            end
            tick();
        end
        shown = 237;
    endtask

    task automatic test_blanking();
        int vals[8] = '{5, 40, 0, 9, 10, 99, 100, 255};
        int bc;
        logic [20:0] cap;
        bit ok;
        foreach (vals[i]) begin
            run_show(vals[i], bc);
            checks++; if (bc != 8) begin failures++; $display("FAIL blank_busy v=%0d got=%0d exp=8", vals[i], bc); end
            capture(cap, ok);
            checks++; if (!ok) begin failures++; $display("FAIL blank_scan v=%0d got=missing_digit exp=all_three", vals[i]); end
            for (int p = 0; p < 3; p++) begin
                checks++;
                if (cap[p*7 +: 7] !== exp_seg(vals[i], p)) begin
                    failures++; $display("FAIL blank_v%0d_digit%0d got=%b exp=%b", vals[i], p, cap[p*7 +: 7], exp_seg(vals[i], p));
                end
            end
            shown = vals[i];
        end
    endtask

    task automatic test_hold_show();
        int busy_hi = 0;
        int rises   = 0;
        logic prev  = 1'b0;
        logic [20:0] cap;
        bit ok;
        Result = 8'd12;
        Sel    = 3'b011;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (i == 2) Result = 8'd99;
            if (Busy === 1'b1) busy_hi++;
            if (Busy === 1'b1 && prev === 1'b0) rises++;
            prev = Busy;
        end
        Sel = 3'b000;
        checks++; if (rises != 1) begin failures++; $display("FAIL hold_pulses got=%0d exp=1", rises); end
        checks++; if (busy_hi != 8) begin failures++; $display("FAIL hold_busy got=%0d exp=8", busy_hi); end
        capture(cap, ok);
        for (int p = 0; p < 3; p++) begin
            checks++;
            if (!ok || cap[p*7 +: 7] !== exp_seg(12, p)) begin
                failures++; $display("FAIL hold_digit%0d got=%b exp=%b", p, cap[p*7 +: 7], exp_seg(12, p));
            end
        end
        shown = 12;
    endtask

    task automatic test_clear_mid();
        int bc;
        logic [20:0] cap;
        bit ok;
        Result = 8'd255;
        Sel    = 3'b011;
        tick();
        Sel    = 3'b000;
        repeat (3) tick();
        checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL clear_prebusy got=%b exp=1", Busy); end
        Sel = 3'b100;
        tick();
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL clear_busy got=%b exp=0", Busy); end
        Sel = 3'b000;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL clear_stays_idle i=%0d got=%b exp=0", i, Busy); end
        end
        capture(cap, ok);
        for (int p = 0; p < 3; p++) begin
            checks++;
            if (!ok || cap[p*7 +: 7] !== exp_seg(0, p)) begin
                failures++; $display("FAIL clear_digit%0d got=%b exp=%b", p, cap[p*7 +: 7], exp_seg(0, p));
            end
        end
        run_show(255, bc);
        checks++; if (bc != 8) begin failures++; $display("FAIL reshow_busy got=%0d exp=8", bc); end
        capture(cap, ok);
        for (int p = 0; p < 3; p++) begin
            checks++;
            if (!ok || cap[p*7 +: 7] !== exp_seg(255, p)) begin
                failures++; $display("FAIL reshow_digit%0d got=%b exp=%b", p, cap[p*7 +: 7], exp_seg(255, p));
            end
        end
        shown = 255;
    endtask

    task automatic test_ignore_busy();
        int cnt = 0;
        logic [20:0] cap;
        bit ok;
        Result = 8'd100;
        Sel    = 3'b011;
        tick(); if (Busy === 1'b1) cnt++;
        Sel = 3'b000;
        tick(); if (Busy === 1'b1) cnt++;
        Result = 8'd7;
        Sel    = 3'b011;
        tick(); if (Busy === 1'b1) cnt++;
        Sel = 3'b000;
        for (int g = 0; g < 20; g++) begin
            tick();
            if (Busy === 1'b1) cnt++;
            else break;
        end
        checks++; if (cnt != 8) begin failures++; $display("FAIL ignore_busy_len got=%0d exp=8", cnt); end
        capture(cap, ok);
        for (int p = 0; p < 3; p++) begin
            checks++;
            if (!ok || cap[p*7 +: 7] !== exp_seg(100, p)) begin
                failures++; $display("FAIL ignore_digit%0d got=%b exp=%b", p, cap[p*7 +: 7], exp_seg(100, p));
            end
        end
        shown = 100;
    endtask

    task automatic test_reset_mid();
        logic [20:0] cap;
        bit ok;
        Result = 8'd200;
        Sel    = 3'b011;
        tick();
        Sel = 3'b000;
        repeat (4) tick();
        checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL rstmid_prebusy got=%b exp=1", Busy); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", Busy); end
        checks++; if (Seg !== 7'b0) begin failures++; $display("FAIL rstmid_seg got=%b exp=%b", Seg, 7'b0); end
        checks++; if (An !== 3'b001) begin failures++; $display("FAIL rstmid_an got=%b exp=001", An); end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL rstmid_after_busy got=%b exp=0", Busy); end
        checks++; if (Seg !== 7'b0111111) begin failures++; $display("FAIL rstmid_units got=%b exp=0111111", Seg); end
        capture(cap, ok);
        for (int p = 0; p < 3; p++) begin
            checks++;
            if (!ok || cap[p*7 +: 7] !== exp_seg(0, p)) begin
                failures++; $display("FAIL rstmid_digit%0d got=%b exp=%b", p, cap[p*7 +: 7], exp_seg(0, p));
            end
        end
        shown = 0;
    endtask

    // Random values, with ignored opcodes and Result churn between shows.
    task automatic test_random();
        logic [2:0] noise[6] = '{3'b000, 3'b001, 3'b010, 3'b101, 3'b110, 3'b111};
        int v;
        int bc;
        logic [20:0] cap;
        bit ok;
        for (int it = 0; it < 25; it++) begin
            for (int j = 0; j < int'($urandom_range(1, 5)); j++) begin
                Sel    = noise[$urandom_range(0, 5)];
                Result = 8'($urandom_range(0, 255));
                tick();
            end
            Sel = 3'b000;
            capture(cap, ok);
            for (int p = 0; p < 3; p++) begin
                checks++;
                if (!ok || cap[p*7 +: 7] !== exp_seg(shown, p)) begin
                    failures++; $display("FAIL rand_hold it=%0d digit%0d got=%b exp=%b", it, p, cap[p*7 +: 7], exp_seg(shown, p));
                end
            end
            v = int'($urandom_range(0, 255));
            run_show(v, bc);
            checks++; if (bc != 8) begin failures++; $display("FAIL rand_busy v=%0d got=%0d exp=8", v, bc); end
            capture(cap, ok);
            for (int p = 0; p < 3; p++) begin
                checks++;
                if (!ok || cap[p*7 +: 7] !== exp_seg(v, p)) begin
                    failures++; $display("FAIL rand_show v=%0d digit%0d got=%b exp=%b", v, p, cap[p*7 +: 7], exp_seg(v, p));
                end
            end
            shown = v;
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_show_237();
        test_blanking();
        test_hold_show();
        test_clear_mid();
        test_ignore_busy();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/result_display.md
Name: result_display

Overview:
- Output-side counterpart to the calculator's operand-entry holders: captures the 8-bit ALU result on the "show" opcode and presents it to the user.
- Converts the result to three BCD digits using a sequential double-dabble, one shift per cycle.
- Drives a time-multiplexed 3-digit seven-segment display with leading-zero blanking.
- Sits between the ALU result bus and the board display pins; shares the 3-bit Sel opcode bus with the operand holders.

Parameters:
- SCAN_DIV, 16: clock cycles each digit stays enabled before the scan advances; legal range 2 to 65535.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- Result  input  8  unsigned ALU result, 0..255.
- Sel  input  3  opcode bus. 3'b011 = show; 3'b100 = clear; other codes are ignored by this block.
- Seg  output  7  segment drive, active high. Seg[0]=a … Seg[6]=g.
- An  output  3  one-hot digit enable, active high. An[0]=units, An[1]=tens, An[2]=hundreds.
- Busy  output  1  high while a conversion is in progress.

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset values (reset_n low):
  - Seg=7'b0000000, An=3'b001, Busy=0.
  - Digit registers = 0; scan counter = 0; scan index = units.
  - FSM = IDLE; show-edge register = 0.
- Show trigger (rising edge of decode, not level):
  - show_q is a registered copy of (Sel==3'b011).
  - start = (Sel==3'b011) & ~show_q.
  - Sel held at 011 for many cycles produces exactly one start.
- FSM states: IDLE, CONV.
  - IDLE, start: load Result into the shift register, clear the BCD accumulator, set iteration count to 0, Busy←1, go to CONV.
  - CONV, each edge: apply add-3 to any BCD nibble ≥5, then shift left 1 bit. Iteration count increments.
  - CONV, 8th shift edge: copy hundreds/tens/units into the display digit registers atomically, Busy←0, go to IDLE.
  - Busy is high for exactly 8 cycles. Displayed digits change on the same edge Busy falls.
- start while in CONV is ignored; the in-flight conversion completes with the original value.
- Clear (Sel==3'b100) has priority over everything, in any state:
  - Abort any conversion; FSM←IDLE; Busy←0.
  - Digit registers←0, which displays "0".
  - Takes effect on the edge where Sel==3'b100 is sampled.
- Digit registers only change on conversion completion or clear. Result changing at any other time has no effect.
- Scan:
  - The counter counts 0..SCAN_DIV-1. On the terminal count it wraps to 0 and the index advances units→tens→hundreds→units.
  - An is registered one-hot of the index and always has exactly one bit set.
- Seg is registered every cycle as decode(digit[index]), 1-cycle latency from a digit or index change:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
- Blanking:
  - Hundreds are blank (Seg=0) when the hundreds digit is 0.
  - Tens are blank when both hundreds and tens are 0.
  - Units are never blank.
- reset_n asserted mid-conversion returns immediately to the reset values; no partial digits appear.

Test Plan:
- Reset: hold reset_n low, then release → Seg=0, An=001, Busy=0. After 1 cycle, units shows 0111111; tens and hundreds are blank.
- Show 237: Result=8'd237, Sel=011 for 1 cycle → Busy high for exactly 8 cycles, then digits 2/3/7. Scan with SCAN_DIV=4 gives An 001,010,100 every 4 cycles with Seg 0000111, 1001111, 1011011.
- Blanking, Result=5 then show → hundreds and tens give Seg=0; units gives 1101101. Result=40 → hundreds blank, tens 1100110, units 0111111.
- Hold Sel=011 for 30 cycles with Result changing from 12 to 99 at cycle 3 → single conversion; display shows 12; Busy pulses once.
- Clear mid-conversion: show 255, then Sel=100 on the 4th Busy cycle → Busy falls on that edge, digits 0, display "0". A subsequent show 255 displays 2/5/5.
- Ignore while busy / reset mid-op: show 100, then show 7 during Busy → display 1/0/0. Separately, reset_n low on Busy cycle 5 → all reset values immediately, before the next clock edge.
